// File: rtl/matrix_pkg.sv
// Shared definitions for the LED matrix panel scanner: FSM states, geometry
// and the bit layout of a frame-buffer column word.
package matrix_pkg;
    localparam int NCOLS     = 32;
    localparam int NROWPAIRS = 8;
    localparam int COLOR_LSB = 16;
    localparam int COLOR_MSB = 18;
    localparam int ADDR_W    = 10;
    localparam int DCNT_W    = 12;

    typedef enum logic [2:0] {
        IDLE, FETCH, WAIT, SETUP, CLOCK, BLANK, LATCH, DISPLAY
    } state_t;
endpackage

// File: rtl/disp_ctr.sv
// Loadable down-counter timing the DISPLAY phase; done flags the last cycle.
module disp_ctr #(
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Loaded with N on entry to DISPLAY, so reaching 1 marks the Nth cycle.
    assign done = (cnt == CNT_W'(1));
endmodule

// File: rtl/matrix_scanner.sv
// HUB75-style panel scanner: fetches column words, shifts colour bits out per
// row pair, then blanks, latches and displays the pair for DISP_CYCLES clocks.
module matrix_scanner #(
    parameter int DISP_CYCLES = 256,
    parameter int NCOLS       = matrix_pkg::NCOLS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [9:0]  start_addr,
    output logic        rd_en,
    output logic [9:0]  rd_addr,
    input  logic [31:0] rd_data,
    output logic        r1,
    output logic        g1,
    output logic        b1,
    output logic        r2,
    output logic        g2,
    output logic        b2,
    output logic        sclk,
    output logic        lat,
    output logic        oe_n,
    output logic [2:0]  row_addr,
    output logic        frame_done
);
    import matrix_pkg::*;

    state_t            state;
    logic [ADDR_W-1:0] shadow;
    logic [ADDR_W-1:0] col;
    logic [ADDR_W-1:0] col_nxt;
    logic [2:0]        pair;
    logic              ctr_load;
    logic              ctr_done;
    logic              unused_rd_bits;

    assign col_nxt        = col + ADDR_W'(1);
    assign ctr_load       = (state == LATCH);
    assign unused_rd_bits = ^rd_data[31:COLOR_MSB+1];

    disp_ctr #(.CNT_W(DCNT_W)) u_disp_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (ctr_load),
        .load_val (DCNT_W'(DISP_CYCLES)),
        .done     (ctr_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            shadow     <= '0;
            col        <= '0;
            pair       <= '0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            {r1, g1, b1} <= 3'b000;
            {r2, g2, b2} <= 3'b000;
            sclk       <= 1'b0;
            lat        <= 1'b0;
            oe_n       <= 1'b1;
            row_addr   <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    rd_en        <= 1'b0;
                    rd_addr      <= '0;
                    {r1, g1, b1} <= 3'b000;
                    {r2, g2, b2} <= 3'b000;
                    sclk         <= 1'b0;
                    lat          <= 1'b0;
                    oe_n         <= 1'b1;
                    row_addr     <= '0;
                    col          <= '0;
                    pair         <= '0;
                    if (en) begin
                        shadow  <= start_addr;
                        rd_en   <= 1'b1;
                        rd_addr <= start_addr;
                        state   <= FETCH;
                    end
                end
                FETCH: begin
                    rd_en <= 1'b0;
                    state <= WAIT;
                end
                // rd_data is valid now; colours register straight into SETUP.
                WAIT: begin
                    {r1, g1, b1} <= rd_data[{1'b0, pair}] ? rd_data[COLOR_MSB:COLOR_LSB] : 3'b000;
                    {r2, g2, b2} <= rd_data[{1'b1, pair}] ? rd_data[COLOR_MSB:COLOR_LSB] : 3'b000;
                    sclk  <= 1'b0;
                    state <= SETUP;
                end
                SETUP: begin
                    sclk  <= 1'b1;
                    state <= CLOCK;
                end
                CLOCK: begin
                    sclk <= 1'b0;
                    if (col != ADDR_W'(NCOLS - 1)) begin
                        col     <= col_nxt;
                        rd_en   <= 1'b1;
                        rd_addr <= shadow + col_nxt;
                        state   <= FETCH;
                    end else begin
                        state <= BLANK;
                    end
                end
                BLANK: begin
                    lat      <= 1'b1;
                    row_addr <= pair;
                    state    <= LATCH;
                end
                LATCH: begin
                    lat   <= 1'b0;
                    oe_n  <= 1'b0;
                    state <= DISPLAY;
                end
                DISPLAY: begin
                    if (ctr_done) begin
                        oe_n <= 1'b1;
                        col  <= '0;
                        if (pair == 3'(NROWPAIRS - 1)) begin
                            frame_done <= 1'b1;
                            pair       <= '0;
                            if (en) begin
                                shadow  <= start_addr;
                                rd_en   <= 1'b1;
                                rd_addr <= start_addr;
                                state   <= FETCH;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            pair <= pair + 3'd1;
                            if (en) begin
                                rd_en   <= 1'b1;
                                rd_addr <= shadow;
                                state   <= FETCH;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
